kernel_launcher: RTL and testbench

//  Initiator side of the synthesized-kernel start/done protocol (r_enable / init_* / w_enable / result).

---
 rtl/kernel_launcher_pkg.sv | 22 ++
 rtl/kernel_launcher_if.sv | 35 +++
 rtl/kernel_launcher.sv | 106 ++++++++++
 tb/tb_kernel_launcher.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_launcher_pkg.sv
// Shared definitions for the kernel start/done initiator: launcher states,
// default geometry and the lane-slice helper for the packed init buses.
package kernel_host_pkg;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_N_ARGS  = 7;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1000;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    RESP    = 2'd3
  } launch_state_e;

  // Lane i of a packed multi-operand bus starts at this bit.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/kernel_launcher_if.sv
// Operand stream, kernel start/done bus and response stream of one launcher.
// The slave view is the launcher itself; the master view is its surroundings.
interface kernel_launcher_if
  import kernel_host_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_ARGS = DEF_N_ARGS,
  parameter int CNT_W  = DEF_CNT_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     k_r_enable;
  logic [N_ARGS*DATA_W-1:0] k_init;
  logic                     k_w_enable;
  logic [DATA_W-1:0]        k_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [CNT_W-1:0]         out_cycles;
  logic                     out_err;
  logic                     busy;

  modport master (
    output in_valid, in_data, k_w_enable, k_result, out_ready,
    input  in_ready, k_r_enable, k_init, out_valid, out_data, out_cycles, out_err, busy
  );

  modport slave (
    input  in_valid, in_data, k_w_enable, k_result, out_ready,
    output in_ready, k_r_enable, k_init, out_valid, out_data, out_cycles, out_err, busy
  );

endinterface

// File: rtl/kernel_launcher.sv
// Start/done initiator: gathers N_ARGS operands, launches one kernel run, then
// reports the result, the WAIT latency and a timeout flag on a response stream.
module kernel_launcher
  import kernel_host_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_ARGS  = DEF_N_ARGS,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic              clk,
  input logic              rst_n,
  kernel_launcher_if.slave bus
);

  localparam int IDX_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;

  localparam logic [1:0] S_COLLECT = COLLECT;
  localparam logic [1:0] S_LAUNCH  = LAUNCH;
  localparam logic [1:0] S_WAIT    = WAIT;
  localparam logic [1:0] S_RESP    = RESP;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  counter;
  logic              r_enable_q;
  logic [DATA_W-1:0] lanes [N_ARGS];
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CNT_W-1:0]  out_cycles_q;
  logic              out_err_q;

  // k_r_enable is raised on the edge that accepts the last operand, so it is
  // high for exactly the LAUNCH cycle; k_w_enable is only looked at in WAIT,
  // by which time the kernel has seen the pulse and dropped its old done flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_COLLECT;
      idx          <= '0;
      counter      <= '0;
      r_enable_q   <= 1'b0;
      for (int i = 0; i < N_ARGS; i++) lanes[i] <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cycles_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      r_enable_q <= 1'b0;
      case (state)
        S_COLLECT: begin
          if (bus.in_valid) begin
            lanes[idx] <= bus.in_data;
            if (idx == IDX_W'(N_ARGS - 1)) begin
              idx        <= '0;
              r_enable_q <= 1'b1;
              state      <= S_LAUNCH;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_LAUNCH: begin
          counter <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.k_w_enable) begin
            out_data_q   <= bus.k_result;
            out_cycles_q <= counter;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b1;
            state        <= S_RESP;
          end else if (counter == CNT_W'(TIMEOUT - 1)) begin
            out_data_q   <= '0;
            out_cycles_q <= CNT_W'(TIMEOUT);
            out_err_q    <= 1'b1;
            out_valid_q  <= 1'b1;
            state        <= S_RESP;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= S_COLLECT;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

  for (genvar g = 0; g < N_ARGS; g++) begin : g_lane
    assign bus.k_init[lane_lsb(g, DATA_W) +: DATA_W] = lanes[g];
  end

  assign bus.in_ready   = (state == S_COLLECT);
  assign bus.busy       = (state != S_COLLECT);
  assign bus.k_r_enable = r_enable_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_cycles = out_cycles_q;
  assign bus.out_err    = out_err_q;

endmodule

// File: tb/tb_kernel_launcher.sv
// Self-checking bench for kernel_launcher: a job-level timeline model plus a
// stub kernel with programmable done latency and add7 / fixed-result modes.
module tb_kernel_launcher;
  import kernel_host_pkg::*;

  localparam int DW = 64;
  localparam int NA = 7;
  localparam int CW = 16;
  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kernel_launcher_if #(.DATA_W(DW), .N_ARGS(NA), .CNT_W(CW)) bus();

  kernel_launcher #(.DATA_W(DW), .N_ARGS(NA), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          delay;
    bit          fixed;
    bit          has_lit;
    logic [DW-1:0] lit_data;
    logic [CW-1:0] lit_cycles;
    bit          lit_err;
  } job_t;

  logic [DW-1:0] op_q[$];
  job_t          job_q[$];

  // Model: operands accepted so far, and for a launched job the number of
  // edges since its last operand; the response appears 1+min(d+1,TIMEOUT) later.
  bit            m_busy;
  bit            m_accepted;
  int            m_idx;
  int            m_t;
  int            m_resp_at;
  logic [DW-1:0] m_lanes [NA];
  bit            m_out_valid;
  logic [DW-1:0] m_out_data;
  logic [CW-1:0] m_out_cycles;
  bit            m_out_err;
  logic [DW-1:0] m_sum;
  job_t          m_job;

  int kern_delay = 1;
  bit kern_fixed = 1'b0;
  bit rdy_always = 1'b1;
  int rdy_low = 0;

  function automatic void model_reset();
    m_busy = 1'b0;
    m_accepted = 1'b0;
    m_idx = 0;
    m_t = 0;
    m_resp_at = 0;
    for (int i = 0; i < NA; i++) m_lanes[i] = '0;
    m_out_valid = 1'b0;
    m_out_data = '0;
    m_out_cycles = '0;
    m_out_err = 1'b0;
  endfunction

  always @(posedge clk) begin
    m_accepted = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_lanes[m_idx] = bus.in_data;
        m_accepted = 1'b1;
        m_idx++;
        if (m_idx == NA) begin
          m_idx = 0;
          m_busy = 1'b1;
          m_t = 0;
          if (job_q.size() > 0) m_job = job_q.pop_front();
          else begin
            m_job.delay = 1;
            m_job.fixed = 1'b0;
            m_job.has_lit = 1'b0;
          end
          m_sum = '0;
          for (int i = 0; i < NA; i++) m_sum = m_sum + m_lanes[i];
          m_resp_at = 1 + ((m_job.delay + 1 < TO) ? m_job.delay + 1 : TO);
          kern_delay = m_job.delay;
          kern_fixed = m_job.fixed;
        end
      end
    end else if (m_out_valid && bus.out_ready) begin
      m_out_valid = 1'b0;
      m_busy = 1'b0;
    end else begin
      m_t++;
      if (m_t == m_resp_at) begin
        m_out_valid = 1'b1;
        if (m_job.delay < TO) begin
          m_out_data = m_job.fixed ? DW'(64'hDEAD_BEEF) : m_sum;
          m_out_cycles = CW'(m_job.delay);
          m_out_err = 1'b0;
        end else begin
          m_out_data = '0;
          m_out_cycles = CW'(TO);
          m_out_err = 1'b1;
        end
      end
    end
  end

  // Stub kernel: no reset, done is sticky until the next start pulse and rises
  // after kern_delay low WAIT cycles.
  logic          k_done = 1'b0;
  logic [DW-1:0] k_res = '0;
  int            k_cnt = 0;
  int            k_d = 0;
  logic [DW-1:0] k_sum;

  always @(posedge clk) begin
    if (bus.k_r_enable) begin
      k_sum = '0;
      for (int i = 0; i < NA; i++) k_sum = k_sum + bus.k_init[i*DW +: DW];
      k_res  <= kern_fixed ? DW'(64'hDEAD_BEEF) : k_sum;
      k_done <= 1'b0;
      k_cnt  <= 1;
      k_d    <= kern_delay;
    end else if (!k_done) begin
      if (k_cnt >= k_d) k_done <= 1'b1;
      else k_cnt <= k_cnt + 1;
    end
  end

  assign bus.k_w_enable = k_done;
  assign bus.k_result   = k_res;

  function automatic void check_output(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Every cycle: all outputs against the model; on a fresh response of a
  // directed job, also against the hand-computed literal values.
  bit prev_ov = 1'b0;
  always @(negedge clk) begin
    check_output("in_ready",   DW'(bus.in_ready),   DW'(!m_busy));
    check_output("busy",       DW'(bus.busy),       DW'(m_busy));
    check_output("k_r_enable", DW'(bus.k_r_enable), DW'(m_busy && m_t == 0));
    check_output("out_valid",  DW'(bus.out_valid),  DW'(m_out_valid));
    check_output("out_data",   bus.out_data,        m_out_data);
    check_output("out_cycles", DW'(bus.out_cycles), DW'(m_out_cycles));
    check_output("out_err",    DW'(bus.out_err),    DW'(m_out_err));
    for (int i = 0; i < NA; i++)
      check_output($sformatf("k_init%0d", i), bus.k_init[i*DW +: DW], m_lanes[i]);
    if (m_out_valid && !prev_ov && m_job.has_lit) begin
      check_output("lit_data",   bus.out_data,        m_job.lit_data);
      check_output("lit_cycles", DW'(bus.out_cycles), DW'(m_job.lit_cycles));
      check_output("lit_err",    DW'(bus.out_err),    DW'(m_job.lit_err));
    end
    prev_ov = m_out_valid;
  end

  task automatic add_job(input bit seq, input logic [DW-1:0] first, input int delay, input bit fixed,
                         input bit has_lit, input logic [DW-1:0] ld, input int lc, input bit le);
    job_t j;
    for (int i = 0; i < NA; i++)
      op_q.push_back(seq ? first + DW'(i) : {$urandom, $urandom});
    j.delay = delay;
    j.fixed = fixed;
    j.has_lit = has_lit;
    j.lit_data = ld;
    j.lit_cycles = CW'(lc);
    j.lit_err = le;
    job_q.push_back(j);
  endtask

  // Called #1 after each edge: retire the accepted operand, then offer the
  // next one with random gaps; while busy, offer garbage that must be ignored.
  task automatic apply_stimulus();
    if (m_accepted && op_q.size() > 0) void'(op_q.pop_front());
    if (!m_busy && op_q.size() > 0 && $urandom_range(0, 2) != 0) begin
      bus.in_valid = 1'b1;
      bus.in_data  = op_q[0];
    end else begin
      bus.in_valid = m_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.in_data  = {$urandom, $urandom};
    end
    if (rdy_always) bus.out_ready = 1'b1;
    else if (rdy_low > 0) begin
      bus.out_ready = 1'b0;
      rdy_low--;
    end else if ($urandom_range(0, 5) == 0) begin
      bus.out_ready = 1'b0;
      rdy_low = 4;
    end else bus.out_ready = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      apply_stimulus();
      n++;
    end while ((op_q.size() != 0 || m_busy) && n < budget);
    checks++;
    if (n >= budget) begin
      failures++;
      $display("[TB] FAIL run_timeout: got %0d cycles expected fewer than %0d", n, budget);
    end
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    add_job(1'b1, 64'd1, 8, 1'b0, 1'b1, 64'd28, 8, 1'b0);
    run_until_idle(200);

    rdy_always = 1'b0;
    add_job(1'b0, 64'd0, 3, 1'b1, 1'b1, 64'hDEAD_BEEF, 3, 1'b0);
    add_job(1'b0, 64'd0, 1000, 1'b0, 1'b1, 64'd0, TO, 1'b1);
    add_job(1'b1, 64'd10, 2, 1'b0, 1'b1, 64'd91, 2, 1'b0);
    add_job(1'b0, 64'd0, TO - 1, 1'b1, 1'b1, 64'hDEAD_BEEF, TO - 1, 1'b0);
    add_job(1'b0, 64'd0, TO, 1'b1, 1'b1, 64'd0, TO, 1'b1);
    add_job(1'b0, 64'd0, 1, 1'b0, 1'b0, 64'd0, 0, 1'b0);
    run_until_idle(1000);

    add_job(1'b0, 64'd0, 5, 1'b0, 1'b0, 64'd0, 0, 1'b0);
    n = 0;
    while (m_idx != 4 && n < 200) begin
      @(posedge clk);
      #1;
      apply_stimulus();
      n++;
    end
    check_output("partial_count", DW'(m_idx), DW'(4));
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    op_q.delete();
    job_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    add_job(1'b1, 64'd1, 8, 1'b0, 1'b1, 64'd28, 8, 1'b0);
    run_until_idle(500);

    for (int j = 0; j < 30; j++)
      add_job(1'b0, 64'd0, $urandom_range(1, TO + 2), 1'($urandom_range(0, 1)), 1'b0, 64'd0, 0, 1'b0);
    run_until_idle(5000);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (40000) @(posedge clk);
    failures++;
    $display("[TB] FAIL watchdog: got 40000 cycles expected completion earlier");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
